// File: rtl/dmem_sram_ctrl.sv
// Data-memory slave: one request in flight, fixed access latency, byte-masked stores,
// full-word loads, responses returned over a valid/ready handshake.
module dmem_sram_ctrl #(
   parameter int unsigned                CPU_WIDTH  = 32,
   parameter int unsigned                DEPTH_LOG2 = 10,
   parameter int unsigned                LATENCY    = 2,
   parameter logic [CPU_WIDTH-1:0]       BASE_ADDR  = 32'h8000_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_wen_i,
   input  logic [CPU_WIDTH-1:0] req_addr_i,
   input  logic [CPU_WIDTH-1:0] req_wdata_i,
   input  logic [3:0]           req_wmask_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [CPU_WIDTH-1:0] resp_rdata_o,
   output logic                 resp_err_o
);

   localparam int unsigned          Words    = 2 ** DEPTH_LOG2;
   localparam logic [CPU_WIDTH-1:0] MemBytes = CPU_WIDTH'(Words * 4);
   localparam logic [3:0]           CntInit  = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   wen_q, wen_d;
   logic [CPU_WIDTH-1:0]   addr_q, addr_d;
   logic [CPU_WIDTH-1:0]   wdata_q, wdata_d;
   logic [3:0]             wmask_q, wmask_d;
   logic [CPU_WIDTH-1:0]   rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic                   mem_we;

   logic [CPU_WIDTH-1:0]   mem_q [Words];
   logic [CPU_WIDTH-1:0]   offset;
   logic                   in_range;
   logic [DEPTH_LOG2-1:0]  idx;

   // Wrapping subtraction makes addresses below BASE_ADDR land far out of range.
   assign offset   = addr_q - BASE_ADDR;
   assign in_range = offset < MemBytes;
   assign idx      = offset[DEPTH_LOG2+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               wen_d   = req_wen_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               wmask_d = req_wmask_i;
               cnt_d   = CntInit;
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               err_d   = ~in_range;
               rdata_d = (!wen_q && in_range) ? mem_q[idx] : '0;
               mem_we  = wen_q && in_range;
               state_d = StResp;
            end
         end
         StResp: begin
            if (resp_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array is not reset; a reset coinciding with the commit edge suppresses the write.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign req_ready_o  = (state_q == StIdle);
   assign resp_valid_o = (state_q == StResp);
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Bench for dmem_sram_ctrl: directed and random transactions against a word-array model,
// plus a LATENCY=1 instance for back-to-back throughput and reset/commit collision.
module tb_dmem_sram_ctrl;

   localparam logic [31:0] Base = 32'h8000_0000;
   localparam int          Lat0 = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_wen, resp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid1, req_wen1, resp_ready1;
   logic [31:0] req_addr1, req_wdata1;
   logic [3:0]  req_wmask1;
   logic        req_ready1, resp_valid1, resp_err1;
   logic [31:0] resp_rdata1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] mem_m  [int unsigned];
   logic [31:0] mem1_m [int unsigned];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_sram_ctrl #(.CPU_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(Lat0), .BASE_ADDR(Base)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
   );

   dmem_sram_ctrl #(.CPU_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(Base)) dut1 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_wen_i(req_wen1),
      .req_addr_i(req_addr1), .req_wdata_i(req_wdata1), .req_wmask_i(req_wmask1),
      .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready1),
      .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: 4 KiB window at Base, word-granular, lanes chosen by mask only.
   task automatic model(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, output logic [31:0] er, output logic ee);
      logic [31:0] off;
      logic [31:0] w;
      int unsigned wi;
      off = addr - Base;
      ee  = (off >= 32'd4096);
      er  = 32'd0;
      if (!ee) begin
         wi = off / 4;
         w  = mem_m.exists(wi) ? mem_m[wi] : 32'hxxxx_xxxx;
         if (wen) begin
            for (int i = 0; i < 4; i++) if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
            mem_m[wi] = w;
         end else begin
            er = w;
         end
      end
   endtask

   task automatic issue(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
      n = 0;
      while (!req_ready && n < 40) begin @(negedge clk); n++; end
      chk("accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      // Post-acceptance input changes must have no effect.
      req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_wmask = 4'($urandom);
   endtask

   task automatic wait_resp(input string tag, input logic [31:0] er, input logic ee);
      int lat;
      lat = 0;
      while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      chk({tag, "_latency"}, lat, Lat0);
      chk({tag, "_rdata"}, resp_rdata, er);
      chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, ee});
   endtask

   task automatic consume(input string tag);
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      chk({tag, "_drop_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic xact(input string tag, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask, input int bp);
      logic [31:0] er;
      logic        ee;
      model(wen, addr, wdata, wmask, er, ee);
      issue(wen, addr, wdata, wmask);
      wait_resp(tag, er, ee);
      repeat (bp) begin
         @(posedge clk); #1;
         chk({tag, "_hold_rdata"}, resp_rdata, er);
         chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      end
      consume(tag);
   endtask

   initial begin
      logic [31:0] er, er2, a, d;
      logic        ee, ee2;
      int          n, acc, prev;
      bit          w;

      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
      req_wmask = '0; resp_ready = 1'b0;
      req_valid1 = 1'b0; req_wen1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
      req_wmask1 = '0; resp_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst1_req_ready", {31'd0, req_ready1}, 32'd1);

      for (int i = 0; i < 16; i++) xact("init", 1'b1, Base + 32'(i * 4), 32'd0, 4'hF, 0);
      xact("init_last", 1'b1, Base + 32'hFFC, 32'hCAFE_F00D, 4'hF, 0);

      xact("st_full", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
      xact("ld_full", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);
      xact("st_lane1", 1'b1, 32'h8000_0010, 32'h0000_00AA, 4'b0010, 0);
      xact("ld_lane1", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);
      xact("st_mask0", 1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, 0);
      xact("ld_mask0", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);
      xact("ld_oor_hi", 1'b0, 32'h8000_1000, 32'h0, 4'h0, 0);
      xact("st_oor_lo", 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0);
      xact("ld_last", 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0);

      // Backpressure: response held 5 cycles while a new request waits.
      model(1'b0, 32'h8000_0010, 32'h0, 4'h0, er, ee);
      model(1'b0, 32'h8000_0000, 32'h0, 4'h0, er2, ee2);
      issue(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      wait_resp("bp", er, ee);
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000; req_wmask = 4'h0;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_rdata", resp_rdata, er);
         chk("bp_err", {31'd0, resp_err}, {31'd0, ee});
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      chk("bp_consumed", {31'd0, resp_valid}, 32'd0);
      chk("bp_not_yet_accepted", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1; req_valid = 1'b0;
      chk("bp_accepted", {31'd0, req_ready}, 32'd0);
      wait_resp("bp2", er2, ee2);
      consume("bp2");

      // Reset during WAIT discards the pending store.
      issue(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("midrst_ready", {31'd0, req_ready}, 32'd1);
      chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
      xact("midrst_ld", 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0);

      for (int k = 0; k < 30; k++) begin
         w = 1'($urandom);
         case ($urandom_range(0, 7))
            0: a = 32'h8000_1000 + 32'($urandom_range(0, 255) * 4);
            1: a = Base - 32'($urandom_range(1, 16) * 4);
            default: a = Base + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
         endcase
         xact("rnd", w, a, $urandom, 4'($urandom), $urandom_range(0, 2));
      end

      // LATENCY=1 instance: held-valid back-to-back stream with resp_ready tied high.
      resp_ready1 = 1'b1;
      req_valid1  = 1'b1;
      prev = 0;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            d = $urandom;
            mem1_m[k] = d; er = 32'd0;
            req_wen1 = 1'b1; req_addr1 = Base + 32'(k * 4); req_wdata1 = d; req_wmask1 = 4'hF;
         end else begin
            er = mem1_m[k - 4];
            req_wen1 = 1'b0; req_addr1 = Base + 32'((k - 4) * 4) + 32'($urandom_range(0, 3));
            req_wdata1 = $urandom; req_wmask1 = 4'($urandom);
         end
         n = 0;
         @(negedge clk);
         while (!req_ready1 && n < 20) begin @(negedge clk); n++; end
         chk("b2b_accept", {31'd0, req_ready1}, 32'd1);
         @(posedge clk); #1;
         acc = cyc;
         if (k > 0) chk("b2b_period", acc - prev, 3);
         prev = acc;
         @(posedge clk); #1;
         chk("b2b_valid", {31'd0, resp_valid1}, 32'd1);
         chk("b2b_rdata", resp_rdata1, er);
         chk("b2b_err", {31'd0, resp_err1}, 32'd0);
      end
      req_valid1 = 1'b0;

      // Reset on the commit edge (LATENCY=1): the store must not land.
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid1 = 1'b1; req_wen1 = 1'b1; req_addr1 = Base; req_wdata1 = ~mem1_m[0];
      req_wmask1 = 4'hF;
      @(posedge clk); #1;
      req_valid1 = 1'b0; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("collide_valid", {31'd0, resp_valid1}, 32'd0);
      chk("collide_ready", {31'd0, req_ready1}, 32'd1);
      @(negedge clk);
      req_valid1 = 1'b1; req_wen1 = 1'b0; req_addr1 = Base;
      @(posedge clk); #1; req_valid1 = 1'b0;
      @(posedge clk); #1;
      chk("collide_ld_valid", {31'd0, resp_valid1}, 32'd1);
      chk("collide_ld_rdata", resp_rdata1, mem1_m[0]);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_sram_ctrl.md
Name: dmem_sram_ctrl

Overview:
Data-memory slave that consumes the store/load requests produced by the load-store stage. It accepts one request at a time over a valid/ready handshake and models a fixed access latency. Writes are byte-masked and reads return a full word. Responses leave over a second valid/ready handshake, which lets the LSU move from immediate DPI writes to a realistic multi-cycle memory port.

Parameters:
CPU_WIDTH, 32, data/address width
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (1024 words = 4 KiB)
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15
BASE_ADDR, 32'h80000000, byte address of word 0

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_wen  input  1  1 = store, 0 = load
req_addr  input  CPU_WIDTH  byte address
req_wdata  input  CPU_WIDTH  store data, byte lane i = bits [8i+7:8i]
req_wmask  input  4  store byte enables, bit i enables lane i
resp_valid  output  1  response present
resp_ready  input  1  consumer takes the response this cycle
resp_rdata  output  CPU_WIDTH  load data; 0 for stores and errors
resp_err  output  1  address out of range

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, latency counter 0. Memory array contents are not reset.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: req_ready = 1. On req_valid & req_ready, latch wen, addr, wdata and wmask; load counter with LATENCY-1; go to WAIT.
  - WAIT: req_ready = 0. If counter != 0, decrement. If counter == 0, commit the access on this edge and go to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are held stable. On resp_ready, go to IDLE and drop resp_valid on the next edge.
- Latency: the acceptance edge is edge 0. resp_valid rises after edge LATENCY. With LATENCY=1, WAIT lasts one cycle.
- Throughput: at most one request in flight. req_ready is 0 in WAIT and RESP, so a new request is never accepted in the same cycle a response is consumed. Peak rate is one request per LATENCY+2 cycles.
- Address decode:
  - offset = latched addr - BASE_ADDR, computed in 32-bit unsigned arithmetic with wrap.
  - In range iff offset < 4 << DEPTH_LOG2. Word index = offset[DEPTH_LOG2+1:2].
  - addr[1:0] is ignored; alignment is the LSU's job and lanes are selected only by wmask.
- Store commit: each lane with wmask bit i = 1 is written; other lanes are unchanged. wmask = 0 writes nothing but still produces a response. resp_rdata = 0, resp_err = 0.
- Load commit: resp_rdata = the full word at the index, as it was before this edge. wmask and wdata are ignored.
- Out of range: no memory write, resp_rdata = 0, resp_err = 1. Latency is the same as a normal access.
- Request inputs are sampled only at acceptance; changes during WAIT or RESP have no effect.
- Reset mid-operation: if rst is asserted in WAIT before the commit edge, the pending store is discarded and memory is untouched. If rst is asserted in RESP, the response is dropped; a committed store remains written.
- rst and the commit edge in the same cycle: reset wins and no write occurs.
- Counter: 4 bits wide; never underflows, because WAIT exits at 0.

Test Plan:
- Store then load, LATENCY=2: store addr 0x80000010, wdata 0xDEADBEEF, wmask 4'b1111, then load 0x80000010 -> resp_rdata 0xDEADBEEF, resp_err 0. resp_valid rises exactly 2 cycles after each acceptance edge.
- Byte mask: after the word holds 0xDEADBEEF, store wdata 0x000000AA with wmask 4'b0010 -> lane 1 takes 0x00 and other lanes are unchanged, so a load returns 0xDEAD00EF. A store with wmask 0 leaves the word unchanged and still responds.
- Out of range: load 0x80001000 (DEPTH_LOG2=10) -> resp_err 1, rdata 0. Store to 0x7FFFFFFC -> resp_err 1; a load of the last word 0x80000FFC is unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err are stable and req_ready stays 0. req_valid driven meanwhile is not accepted until one cycle after resp_ready=1.
- Reset mid-op: store 0x11223344 to 0x80000020 (prior contents 0), assert rst in the first WAIT cycle -> next cycle req_ready 1, resp_valid 0, and a later load returns 0.
- LATENCY=1 build: back-to-back load requests held valid with resp_ready tied 1 -> responses every 3 cycles and data correct.
